// File: rtl/ocl_tile_regbridge.sv
`default_nettype none
// ============================================================================
// Module  : ocl_tile_regbridge
// Brief   : OCL single-beat AW/W/B + AR/R endpoint driving a broadcast tile
//           register bus, with read timeout and a small self-register space.
// Revision: 1.0
// ============================================================================
module ocl_tile_regbridge #(
    parameter int         N_COMP  = 16,
    parameter int         TIMEOUT = 255,
    parameter logic [7:0] SELF_ID = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     ocl_awvalid,
    output logic                     ocl_awready,
    input  logic [31:0]              ocl_awaddr,
    input  logic                     ocl_wvalid,
    output logic                     ocl_wready,
    input  logic [31:0]              ocl_wdata,
    output logic                     ocl_bvalid,
    input  logic                     ocl_bready,
    input  logic                     ocl_arvalid,
    output logic                     ocl_arready,
    input  logic [31:0]              ocl_araddr,
    output logic                     ocl_rvalid,
    output logic [31:0]              ocl_rdata,
    input  logic                     ocl_rready,
    output logic                     reg_wvalid,
    output logic [15:0]              reg_waddr,
    output logic [31:0]              reg_wdata,
    output logic                     reg_arvalid,
    output logic [15:0]              reg_araddr,
    input  logic [N_COMP-1:0]        reg_rvalid,
    input  logic [N_COMP-1:0][31:0]  reg_rdata,
    output logic [15:0]              timeout_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_W  = 3'd1,
        S_W_ISSUE = 3'd2,
        S_B_RESP  = 3'd3,
        S_R_ISSUE = 3'd4,
        S_R_WAIT  = 3'd5,
        S_R_RESP  = 3'd6
    } state_t;

    localparam logic [31:0] c_BAD_DATA = 32'hDEAD_BEEF;

    state_t      state_q, state_d;
    logic [15:0] waddr_q, waddr_d;
    logic [15:0] araddr_q, araddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] tocnt_q, tocnt_d;

    logic [7:0]  rd_id, wr_id;
    logic        rd_self, rd_oor, wr_self;
    logic        sel_rvalid;
    logic [31:0] sel_rdata, self_rdata;
    logic        unused_addr_hi;

    assign rd_id          = araddr_q[15:8];
    assign wr_id          = waddr_q[15:8];
    assign rd_self        = (rd_id == SELF_ID);
    assign wr_self        = (wr_id == SELF_ID);
    assign rd_oor         = !rd_self && ({24'd0, rd_id} >= N_COMP);
    assign unused_addr_hi = ^{ocl_awaddr[31:16], ocl_araddr[31:16]};

    always_comb begin
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < N_COMP; i++) begin
            if ({24'd0, rd_id} == i) begin
                sel_rvalid = reg_rvalid[i];
                sel_rdata  = reg_rdata[i];
            end
        end
    end

    always_comb begin
        self_rdata = '0;
        case (araddr_q[7:0])
            8'h00:   self_rdata = {16'h0000, tocnt_q};
            8'h04:   self_rdata = 32'(N_COMP);
            default: self_rdata = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        araddr_d = araddr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wait_d   = wait_q;
        tocnt_d  = tocnt_q;
        unique case (state_q)
            S_IDLE: begin
                // Write has priority; a concurrent ar stays pending until IDLE returns.
                if (ocl_awvalid) begin
                    waddr_d = ocl_awaddr[15:0];
                    state_d = S_WAIT_W;
                end else if (ocl_arvalid) begin
                    araddr_d = ocl_araddr[15:0];
                    state_d  = S_R_ISSUE;
                end
            end
            S_WAIT_W: begin
                if (ocl_wvalid) begin
                    wdata_d = ocl_wdata;
                    state_d = S_W_ISSUE;
                end
            end
            S_W_ISSUE: begin
                if (wr_self && (waddr_q[7:0] == 8'h00)) tocnt_d = '0;
                state_d = S_B_RESP;
            end
            S_B_RESP: begin
                if (ocl_bready) state_d = S_IDLE;
            end
            S_R_ISSUE: begin
                wait_d  = '0;
                state_d = S_R_WAIT;
            end
            S_R_WAIT: begin
                if (rd_self) begin
                    rdata_d = self_rdata;
                    state_d = S_R_RESP;
                end else if (rd_oor) begin
                    rdata_d = c_BAD_DATA;
                    state_d = S_R_RESP;
                end else if (sel_rvalid) begin
                    rdata_d = sel_rdata;
                    state_d = S_R_RESP;
                end else if (wait_q == 16'(TIMEOUT)) begin
                    rdata_d = c_BAD_DATA;
                    if (tocnt_q != 16'hFFFF) tocnt_d = tocnt_q + 16'd1;
                    state_d = S_R_RESP;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_R_RESP: begin
                if (ocl_rready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            waddr_q  <= '0;
            araddr_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_q   <= '0;
            tocnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            araddr_q <= araddr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wait_q   <= wait_d;
            tocnt_q  <= tocnt_d;
        end
    end

    assign ocl_awready = (state_q == S_IDLE);
    assign ocl_arready = (state_q == S_IDLE);
    assign ocl_wready  = (state_q == S_WAIT_W);
    assign ocl_bvalid  = (state_q == S_B_RESP);
    assign ocl_rvalid  = (state_q == S_R_RESP);
    assign ocl_rdata   = rdata_q;
    assign reg_wvalid  = (state_q == S_W_ISSUE) && !wr_self;
    assign reg_arvalid = (state_q == S_R_ISSUE) && !rd_self && !rd_oor;
    assign reg_waddr   = waddr_q;
    assign reg_wdata   = wdata_q;
    assign reg_araddr  = araddr_q;
    assign timeout_cnt = tocnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ocl_tile_regbridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_ocl_tile_regbridge
// Brief   : Directed self-checking bench for ocl_tile_regbridge.
// Revision: 1.0
// ============================================================================
module tb_ocl_tile_regbridge;

    localparam int          c_NCOMP = 16;
    localparam int          c_TO    = 4;
    localparam int          c_BOUND = 60;
    localparam logic [31:0] c_BAD   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic ocl_awvalid = 1'b0, ocl_wvalid = 1'b0, ocl_bready = 1'b0;
    logic ocl_arvalid = 1'b0, ocl_rready = 1'b0;
    logic [31:0] ocl_awaddr = '0, ocl_wdata = '0, ocl_araddr = '0;
    logic ocl_awready, ocl_wready, ocl_bvalid, ocl_arready, ocl_rvalid;
    logic [31:0] ocl_rdata;
    logic reg_wvalid, reg_arvalid;
    logic [15:0] reg_waddr, reg_araddr, timeout_cnt;
    logic [31:0] reg_wdata;
    logic [c_NCOMP-1:0] reg_rvalid = '0;
    logic [c_NCOMP-1:0][31:0] reg_rdata = '0;

    ocl_tile_regbridge #(.N_COMP(c_NCOMP), .TIMEOUT(c_TO), .SELF_ID(8'hFF)) dut (
        .clk(clk), .rstn(rstn),
        .ocl_awvalid(ocl_awvalid), .ocl_awready(ocl_awready), .ocl_awaddr(ocl_awaddr),
        .ocl_wvalid(ocl_wvalid), .ocl_wready(ocl_wready), .ocl_wdata(ocl_wdata),
        .ocl_bvalid(ocl_bvalid), .ocl_bready(ocl_bready),
        .ocl_arvalid(ocl_arvalid), .ocl_arready(ocl_arready), .ocl_araddr(ocl_araddr),
        .ocl_rvalid(ocl_rvalid), .ocl_rdata(ocl_rdata), .ocl_rready(ocl_rready),
        .reg_wvalid(reg_wvalid), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_arvalid(reg_arvalid), .reg_araddr(reg_araddr),
        .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct { logic [15:0] a; logic [31:0] d; int c; } ev_t;
    ev_t exp_w[$], exp_a[$], exp_r[$], exp_b[$];
    logic [15:0] model_tocnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level read model: data and latency follow from the address class
    // and the cycle (relative to ar acceptance) at which the component answers.
    task automatic predict_read(input logic [15:0] a, input int rdelay, input logic [31:0] cdata,
                                output logic [31:0] d, output int lat, output bit issue,
                                output bit tmo);
        int id, n;
        id = int'(a[15:8]);
        n = 1 + rdelay;
        tmo = 1'b0;
        issue = 1'b0;
        if (id == 255) begin
            lat = 3;
            d = (a[7:0] == 8'h00) ? {16'h0, model_tocnt} : (a[7:0] == 8'h04) ? 32'(c_NCOMP) : 32'h0;
        end else if (id >= c_NCOMP) begin
            lat = 3;
            d = c_BAD;
        end else begin
            issue = 1'b1;
            if (rdelay >= 0 && n >= 2 && n <= 2 + c_TO) begin
                lat = n + 1;
                d = cdata;
            end else begin
                lat = 3 + c_TO;
                d = c_BAD;
                tmo = 1'b1;
            end
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int wgap,
                            input int bhold, output int bcyc);
        int t0, tw, n;
        ocl_awvalid = 1'b1;
        ocl_awaddr = a;
        n = 0;
        while (!ocl_awready && n < c_BOUND) begin step(); n++; end
        chk("awready_wait", ocl_awready, 1'b1);
        t0 = cyc;
        step();
        ocl_awvalid = 1'b0;
        repeat (wgap - 1) step();
        ocl_wvalid = 1'b1;
        ocl_wdata = d;
        n = 0;
        while (!ocl_wready && n < c_BOUND) begin step(); n++; end
        chk("wready_wait", ocl_wready, 1'b1);
        tw = cyc;
        if (a[15:8] != 8'hFF) exp_w.push_back('{a[15:0], d, tw + 1});
        exp_b.push_back('{16'h0, 32'h0, tw + 2});
        step();
        ocl_wvalid = 1'b0;
        if (a[15:8] == 8'hFF && a[7:0] == 8'h00) model_tocnt = '0;
        n = 0;
        while (!ocl_bvalid && n < c_BOUND) begin step(); n++; end
        chk("bvalid_wait", ocl_bvalid, 1'b1);
        for (int i = 0; i < bhold; i++) begin
            chk("bvalid_hold", ocl_bvalid, 1'b1);
            step();
        end
        ocl_bready = 1'b1;
        bcyc = cyc;
        step();
        ocl_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int rdelay, input logic [31:0] cdata,
                           input int rhold, input bit noise, input bit late,
                           output logic [31:0] got, output int lat, output int t0);
        logic [31:0] ed;
        int el, n;
        bit iss, tmo;
        logic [7:0] id;
        id = a[15:8];
        ocl_arvalid = 1'b1;
        ocl_araddr = a;
        n = 0;
        while (!ocl_arready && n < c_BOUND) begin step(); n++; end
        chk("arready_wait", ocl_arready, 1'b1);
        t0 = cyc;
        predict_read(a[15:0], rdelay, cdata, ed, el, iss, tmo);
        if (iss) exp_a.push_back('{a[15:0], 32'h0, t0 + 1});
        exp_r.push_back('{16'h0, ed, t0 + el});
        step();
        ocl_arvalid = 1'b0;
        if (tmo && model_tocnt != 16'hFFFF) model_tocnt = model_tocnt + 16'd1;
        n = 0;
        while (!ocl_rvalid && n < c_BOUND) begin
            reg_rvalid = '0;
            if (rdelay >= 0 && cyc - t0 == 1 + rdelay && id < c_NCOMP) begin
                reg_rvalid[id[3:0]] = 1'b1;
                reg_rdata[id[3:0]] = cdata;
                if (noise && id != 8'd3) begin
                    reg_rvalid[3] = 1'b1;
                    reg_rdata[3] = 32'hBAD0_0003;
                end
            end
            step();
            n++;
        end
        reg_rvalid = '0;
        chk("rvalid_wait", ocl_rvalid, 1'b1);
        got = ocl_rdata;
        lat = cyc - t0;
        if (late && id < c_NCOMP) begin
            reg_rvalid[id[3:0]] = 1'b1;
            reg_rdata[id[3:0]] = 32'h5555_AAAA;
        end
        repeat (rhold) step();
        ocl_rready = 1'b1;
        step();
        ocl_rready = 1'b0;
        if (late) step();
        reg_rvalid = '0;
    endtask

    // Compare process: every strobe/response is matched against the model queues.
    ev_t e;
    bit prev_b = 1'b0, prev_r = 1'b0;
    logic [31:0] held_rdata = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_b = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (reg_wvalid) begin
                if (exp_w.size() == 0) chk("unexp_reg_wvalid", reg_wvalid, 1'b0);
                else begin
                    e = exp_w.pop_front();
                    chk("reg_waddr", reg_waddr, e.a);
                    chk("reg_wdata", reg_wdata, e.d);
                    chk("reg_wvalid_cycle", cyc, e.c);
                end
            end
            if (reg_arvalid) begin
                if (exp_a.size() == 0) chk("unexp_reg_arvalid", reg_arvalid, 1'b0);
                else begin
                    e = exp_a.pop_front();
                    chk("reg_araddr", reg_araddr, e.a);
                    chk("reg_arvalid_cycle", cyc, e.c);
                end
            end
            if (ocl_bvalid && !prev_b) begin
                if (exp_b.size() == 0) chk("unexp_bvalid", ocl_bvalid, 1'b0);
                else begin
                    e = exp_b.pop_front();
                    chk("bvalid_cycle", cyc, e.c);
                end
            end
            if (ocl_rvalid) begin
                if (!prev_r) begin
                    held_rdata = ocl_rdata;
                    if (exp_r.size() == 0) chk("unexp_rvalid", ocl_rvalid, 1'b0);
                    else begin
                        e = exp_r.pop_front();
                        chk("rdata", ocl_rdata, e.d);
                        chk("rvalid_cycle", cyc, e.c);
                    end
                end else begin
                    chk("rdata_hold", ocl_rdata, held_rdata);
                end
            end
            if (ocl_awready) begin
                chk("arready_eq_awready", ocl_arready, 1'b1);
                chk("timeout_cnt", timeout_cnt, model_tocnt);
            end
            prev_b = ocl_bvalid;
            prev_r = ocl_rvalid;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, ocl_awready, 1'b1);
        chk({tag, "_arready"}, ocl_arready, 1'b1);
        chk({tag, "_wready"}, ocl_wready, 1'b0);
        chk({tag, "_bvalid"}, ocl_bvalid, 1'b0);
        chk({tag, "_rvalid"}, ocl_rvalid, 1'b0);
        chk({tag, "_rdata"}, ocl_rdata, 32'h0);
        chk({tag, "_reg_wvalid"}, reg_wvalid, 1'b0);
        chk({tag, "_reg_arvalid"}, reg_arvalid, 1'b0);
        chk({tag, "_reg_waddr"}, reg_waddr, 16'h0);
        chk({tag, "_reg_araddr"}, reg_araddr, 16'h0);
        chk({tag, "_reg_wdata"}, reg_wdata, 32'h0);
        chk({tag, "_timeout_cnt"}, timeout_cnt, 16'h0);
    endtask

    logic [31:0] got;
    int lat, t0r, bcyc, n;

    initial begin
        repeat (2) step();
        chk_reset_outputs("rst");
        rstn = 1'b1;
        step();

        // Plain write, bready held low 5 cycles.
        do_write(32'h0000_0310, 32'hCAFE_0001, 2, 5, bcyc);

        // Component 2 answers 3 cycles after reg_arvalid; ID 3 chatter is ignored.
        do_read(32'h0000_0208, 3, 32'h1234_5678, 2, 1'b1, 1'b0, got, lat, t0r);
        chk("rd2_data_lit", got, 32'h1234_5678);
        chk("rd2_lat_lit", lat, 5);

        // No answer from ID 5: fabricated response, then a late answer is dropped.
        do_read(32'h0000_0510, -1, 32'h0, 2, 1'b0, 1'b1, got, lat, t0r);
        chk("to_data_lit", got, 32'hDEAD_BEEF);
        chk("to_lat_lit", lat, 7);
        chk("to_cnt_lit", timeout_cnt, 16'd1);

        do_read(32'h0000_FF00, -1, 32'h0, 0, 1'b0, 1'b0, got, lat, t0r);
        chk("self0_lit", got, 32'h1);
        chk("self0_lat_lit", lat, 3);
        do_read(32'h0000_FF04, -1, 32'h0, 1, 1'b0, 1'b0, got, lat, t0r);
        chk("self4_lit", got, 32'd16);
        do_read(32'h0000_FF08, -1, 32'h0, 0, 1'b0, 1'b0, got, lat, t0r);
        chk("self8_lit", got, 32'h0);

        do_read(32'h0000_2000, -1, 32'h0, 0, 1'b0, 1'b0, got, lat, t0r);
        chk("oor_lit", got, 32'hDEAD_BEEF);
        chk("oor_lat_lit", lat, 3);

        // aw and ar in the same cycle: write first, read right after bresp.
        ocl_arvalid = 1'b1;
        ocl_araddr = 32'h0000_0104;
        do_write(32'h0000_0114, 32'h0BAD_F00D, 1, 0, bcyc);
        do_read(32'h0000_0104, 1 + 2, 32'h0000_0101, 0, 1'b0, 1'b0, got, lat, t0r);
        chk("order_lit", t0r, bcyc + 1);
        chk("both_rd_lit", got, 32'h0000_0101);

        do_write(32'h0000_FF00, 32'h0, 1, 0, bcyc);
        chk("self_clr_lit", timeout_cnt, 16'd0);

        do_read(32'h0000_0520, -1, 32'h0, 0, 1'b0, 1'b0, got, lat, t0r);
        chk("to2_cnt_lit", timeout_cnt, 16'd1);

        // Reset while waiting on a component.
        ocl_arvalid = 1'b1;
        ocl_araddr = 32'h0000_0604;
        n = 0;
        while (!ocl_arready && n < c_BOUND) begin step(); n++; end
        exp_a.push_back('{16'h0604, 32'h0, cyc + 1});
        step();
        ocl_arvalid = 1'b0;
        step();
        step();
        rstn = 1'b0;
        #1;
        chk_reset_outputs("mid");
        step();
        exp_r.delete();
        exp_w.delete();
        exp_b.delete();
        model_tocnt = '0;
        rstn = 1'b1;
        chk_reset_outputs("post");
        step();
        do_read(32'h0000_070C, 2, 32'h7777_0007, 1, 1'b0, 1'b0, got, lat, t0r);
        chk("post_rd_lit", got, 32'h7777_0007);
        chk("post_lat_lit", lat, 4);

        repeat (3) step();
        chk("left_w", exp_w.size(), 0);
        chk("left_a", exp_a.size(), 0);
        chk("left_r", exp_r.size(), 0);
        chk("left_b", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
